// File: rtl/tile_sched.sv
// Tile engine job scheduler: round-robin arbitration across four requesters,
// one outstanding job at a time, with a WAIT-state timeout and sticky error flag.
module tile_sched #(
   parameter int TIMEOUT_CYC = 1024,
   parameter int MAX_REPEAT  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req_valid,
   output logic [3:0]  req_ready,
   input  logic [15:0] req_repeat,
   output logic        eng_valid,
   input  logic        eng_ready,
   output logic [3:0]  eng_repeat,
   input  logic        eng_out_valid,
   output logic        eng_out_ready,
   output logic [3:0]  rsp_valid,
   input  logic [3:0]  rsp_ready,
   output logic [1:0]  grant_id,
   output logic        busy,
   input  logic        err_clr,
   output logic        timeout_err,
   output logic [15:0] done_count
);

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);
   localparam logic [3:0]  REP_MAX   = 4'(MAX_REPEAT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

   state_t      state, state_nxt;
   logic [1:0]  last_grant;
   logic [15:0] wait_cnt;
   logic [1:0]  pick;
   logic        pick_found;
   logic        do_grant, do_issue, do_timeout, do_done;

   function automatic logic [3:0] clamp_rep(input logic [3:0] r);
      if (r == 4'd0)         return 4'd1;
      else if (r > REP_MAX)  return REP_MAX;
      else                   return r;
   endfunction

   // Search starts one past the last owner so every requester gets a turn.
   always_comb begin
      logic [1:0] idx;
      pick       = '0;
      pick_found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = last_grant + 2'(k);
         if (!pick_found && req_valid[idx]) begin
            pick       = idx;
            pick_found = 1'b1;
         end
      end
   end

   assign busy          = (state != IDLE);
   assign eng_valid     = (state == ISSUE) && req_valid[grant_id];
   assign eng_out_ready = (state == DELIVER) && rsp_ready[grant_id];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_req
         assign req_ready[gi] = eng_valid && eng_ready && (grant_id == 2'(gi));
         assign rsp_valid[gi] = (state == DELIVER) && (grant_id == 2'(gi));
      end
   endgenerate

   always_comb begin
      state_nxt  = state;
      do_grant   = 1'b0;
      do_issue   = 1'b0;
      do_timeout = 1'b0;
      do_done    = 1'b0;
      case (state)
         IDLE: if (pick_found) begin
            do_grant  = 1'b1;
            state_nxt = ISSUE;
         end
         ISSUE: begin
            if (!req_valid[grant_id]) begin
               state_nxt = IDLE;
            end else if (eng_ready) begin
               do_issue  = 1'b1;
               state_nxt = WAIT;
            end
         end
         // A result arriving on the last allowed cycle still counts.
         WAIT: begin
            if (eng_out_valid) begin
               state_nxt = DELIVER;
            end else if (wait_cnt == WAIT_LAST) begin
               do_timeout = 1'b1;
               state_nxt  = IDLE;
            end
         end
         DELIVER: if (rsp_ready[grant_id]) begin
            do_done   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant  <= 2'd3;
         grant_id    <= 2'd0;
         eng_repeat  <= 4'd1;
         wait_cnt    <= '0;
         done_count  <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (do_grant) begin
            grant_id   <= pick;
            eng_repeat <= clamp_rep(req_repeat[4*pick +: 4]);
         end
         if (do_issue)           wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + 16'd1;
         if (do_timeout || do_done) last_grant <= grant_id;
         if (do_done) done_count <= done_count + 16'd1;
         if (do_timeout)   timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;
      end
   end

endmodule
